// File: rtl/edge_detector_multi.sv
// Multi-channel push-button edge detector: 2-FF synchroniser, per-channel level FSM, one-clk ticks.
// Optional per-channel debounce counter enabled by defining EDGE_DEBOUNCE_EN.
module edge_detector_multi #(
  parameter int   CH              = 4,
  parameter int   EDGE_MODE       = 0,
  parameter logic INIT_LEVEL      = 1'b1,
  parameter int   DEBOUNCE_CYCLES = 250000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] level,
  input  logic [CH-1:0] en,
  output logic [CH-1:0] tick,
  output logic [CH-1:0] state,
  output logic          any_tick
);

  logic [CH-1:0] r_sync1;
  logic [CH-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= {CH{INIT_LEVEL}};
      r_sync2 <= {CH{INIT_LEVEL}};
    end else begin
      r_sync1 <= level;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic r_state;
      logic r_tick;
      logic w_diff;
      logic w_take;
      logic w_match;

      assign w_diff = r_sync2[gi] ^ r_state;
      // Unsupported EDGE_MODE values fall back to rising-edge detection.
      assign w_match = (EDGE_MODE == 1) ? ~r_sync2[gi] :
                       (EDGE_MODE == 2) ? 1'b1 : r_sync2[gi];

`ifdef EDGE_DEBOUNCE_EN
      localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      logic [CW-1:0] r_cnt;

      assign w_take = w_diff && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

      // Any return to the current state restarts the stability count.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (!w_diff || w_take) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
`else
      assign w_take = w_diff;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          r_state <= INIT_LEVEL;
          r_tick  <= 1'b0;
        end else begin
          r_tick <= w_take & en[gi] & w_match;
          if (w_take) begin
            r_state <= r_sync2[gi];
          end
        end
      end

      assign state[gi] = r_state;
      assign tick[gi]  = r_tick;
    end
  endgenerate

  assign any_tick = |tick;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Bench for edge_detector_multi: four instances (EDGE_MODE 0..3) share stimulus and are
// checked every cycle against a sample-history model, plus literal spot checks.
module tb_edge_detector_multi;
  localparam int CH  = 4;
  localparam int NM  = 4;
  localparam int DEB = 4;
  localparam logic [CH-1:0] INIT = '1;
`ifdef EDGE_DEBOUNCE_EN
  localparam int LAT  = DEB + 1;
  localparam int DEBN = DEB;
`else
  localparam int LAT  = 2;
  localparam int DEBN = 1;
`endif

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic [CH-1:0] level = '1;
  logic [CH-1:0] en    = '1;
  logic [CH-1:0] d_tick  [NM];
  logic [CH-1:0] d_state [NM];
  logic          d_any   [NM];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < NM; gi++) begin : g_dut
      edge_detector_multi #(
        .CH(CH), .EDGE_MODE(gi), .INIT_LEVEL(1'b1), .DEBOUNCE_CYCLES(DEB)
      ) u_dut (
        .clk(clk), .rst(rst), .level(level), .en(en),
        .tick(d_tick[gi]), .state(d_state[gi]), .any_tick(d_any[gi])
      );
    end
  endgenerate

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the filter sees each level sample two posedges late; a channel changes state once
  // it has seen DEBN consecutive samples differing from its state.
  logic [CH-1:0] q_lvl [$];
  logic [CH-1:0] m_state;
  logic [CH-1:0] m_tick [NM];
  bit            m_valid = 1'b0;
  int            run [CH];

  function automatic logic [CH-1:0] edge_ok(input int mode, input logic [CH-1:0] nv);
    if (mode == 1) return ~nv;
    if (mode == 2) return '1;
    return nv;
  endfunction

  initial begin : model
    logic [CH-1:0] seen;
    logic [CH-1:0] flip;
    forever begin
      @(posedge clk);
      if (rst) begin
        q_lvl = '{INIT, INIT};
        m_state = INIT;
        for (int m = 0; m < NM; m++) m_tick[m] = '0;
        for (int c = 0; c < CH; c++) run[c] = 0;
        m_valid = 1'b1;
      end else if (m_valid) begin
        seen = q_lvl.pop_front();
        q_lvl.push_back(level);
        flip = '0;
        for (int c = 0; c < CH; c++) begin
          if (seen[c] == m_state[c]) begin
            run[c] = 0;
          end else begin
            run[c]++;
            if (run[c] >= DEBN) begin
              flip[c] = 1'b1;
              run[c] = 0;
            end
          end
        end
        m_state = m_state ^ flip;
        for (int m = 0; m < NM; m++) m_tick[m] = flip & en & edge_ok(m, m_state);
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (m_valid) begin
        for (int m = 0; m < NM; m++) begin
          check($sformatf("mode%0d tick", m), 32'(d_tick[m]), 32'(m_tick[m]));
          check($sformatf("mode%0d state", m), 32'(d_state[m]), 32'(m_state));
          check($sformatf("mode%0d any_tick", m), 32'(d_any[m]), 32'(|m_tick[m]));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [CH-1:0] v_lv [11] = '{4'hF, 4'hA, 4'h5, 4'h0, 4'hF, 4'h3, 4'hC, 4'hF, 4'h6, 4'h9, 4'hF};
  logic [CH-1:0] v_en [11] = '{4'hF, 4'hF, 4'hF, 4'h7, 4'h7, 4'hF, 4'hF, 4'hF, 4'h9, 4'hF, 4'hF};
  int            v_hd [11] = '{3, 1, 2, 1, 6, 1, 1, 8, 4, 3, 12};

  initial begin : stim
    // Reset behaviour, including level toggling while reset is held
    step(3);
    check("rst tick", 32'(d_tick[0]), 32'h0);
    check("rst any_tick", 32'(d_any[0]), 32'h0);
    check("rst state", 32'(d_state[0]), 32'hF);
    for (int i = 0; i < 4; i++) begin
      level = CH'(i * 5);
      step(1);
    end
    check("rst hold state", 32'(d_state[2]), 32'hF);
    check("rst hold tick", 32'(d_tick[2]), 32'h0);
    level = '1;
    step(1);
    rst = 1'b0;
    step(10);

    // Single channel press/release, rising mode
    level = 4'hE;
    step(10);
    check("press state", 32'(d_state[0]), 32'hE);
    level = 4'hF;
    step(LAT);
    check("release early tick", 32'(d_tick[0]), 32'h0);
    step(1);
    check("release tick", 32'(d_tick[0]), 32'h1);
    check("release state", 32'(d_state[0]), 32'hF);
    step(1);
    check("release tick width", 32'(d_tick[0]), 32'h0);
    step(8);

    // All channels together, every edge mode
    level = 4'h0;
    step(LAT + 1);
    check("fall both", 32'(d_tick[2]), 32'hF);
    check("fall both any", 32'(d_any[2]), 32'h1);
    check("fall falling", 32'(d_tick[1]), 32'hF);
    check("fall rising", 32'(d_tick[0]), 32'h0);
    step(10);
    level = 4'hF;
    step(LAT + 1);
    check("rise both", 32'(d_tick[2]), 32'hF);
    check("rise rising", 32'(d_tick[0]), 32'hF);
    check("rise falling", 32'(d_tick[1]), 32'h0);
    check("rise mode3", 32'(d_tick[3]), 32'hF);
    step(10);

    // Enable masking; masked edge must not be replayed
    en = 4'b1110;
    level = 4'b1100;
    step(10);
    level = 4'hF;
    step(LAT + 1);
    check("masked tick", 32'(d_tick[0]), 32'h2);
    check("masked state", 32'(d_state[0]), 32'hF);
    en = 4'hF;
    step(5);
    check("no replay", 32'(d_tick[0]), 32'h0);

    // Directed pattern table with short pulses
    for (int i = 0; i < 11; i++) begin
      level = v_lv[i];
      en = v_en[i];
      step(v_hd[i]);
    end

    // Reset in the middle of activity
    level = 4'h5;
    step(1);
    rst = 1'b1;
    level = 4'h0;
    step(2);
    rst = 1'b0;
    level = 4'hF;
    step(10);

`ifdef EDGE_DEBOUNCE_EN
    // Bounce on channel 2 must not tick early
    level = 4'hB;
    step(10);
    level = 4'hF;
    step(2);
    level = 4'hB;
    step(1);
    level = 4'hF;
    for (int p = 0; p < 5; p++) begin
      step(1);
      check("bounce early", 32'(d_tick[0]), 32'h0);
    end
    step(1);
    check("bounce tick", 32'(d_tick[0]), 32'h4);
    check("bounce state", 32'(d_state[0]), 32'hF);
    step(5);

    // Reset mid-count on channel 3 forces a full recount
    level = 4'h7;
    step(4);
    rst = 1'b1;
    step(2);
    check("midcount rst state", 32'(d_state[1]), 32'hF);
    rst = 1'b0;
    for (int p = 0; p < 5; p++) begin
      step(1);
      check("recount early", 32'(d_tick[1]), 32'h0);
    end
    step(1);
    check("recount tick", 32'(d_tick[1]), 32'h8);
    level = 4'hF;
    step(10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
